// File: rtl/arbiter_pkg.sv
// Shared definitions for the shared-memory-bus arbiter.
// Provides the default client count, the client index type and the arbiter FSM state type.
package arbiter_pkg;

    localparam int unsigned ARB_CLIENTS = 4;

    typedef logic [$clog2(ARB_CLIENTS)-1:0] client_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
//   request : one bit per client, raised by the client and held for its whole transaction
//   grant   : one bit per client, driven by the arbiter, one-hot or zero
// Modports: master = client side (drives request), slave = arbiter side (drives grant).
interface bus_arbiter_if
    import arbiter_pkg::*;
#(
    parameter int unsigned Clients = ARB_CLIENTS
) ();

    logic [Clients-1:0] request;
    logic [Clients-1:0] grant;

    modport master (
        output request,
        input  grant
    );

    modport slave (
        input  request,
        output grant
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   start_i  : index that has highest priority this round
//   valid_o  : any request present
//   winner_o : first requesting index at or after start_i, wrapping around
// The request vector is rotated so start_i lands at bit 0, the lowest set bit is found,
// and the result is rotated back into the original index space.
module rr_priority_pick
    import arbiter_pkg::*;
#(
    parameter int unsigned Clients = ARB_CLIENTS,
    parameter int unsigned IdxW    = (Clients > 1) ? $clog2(Clients) : 1
) (
    input  logic [Clients-1:0] req_i,
    input  logic [IdxW-1:0]    start_i,
    output logic               valid_o,
    output logic [IdxW-1:0]    winner_o
);

    logic [Clients-1:0] rot;
    logic [IdxW-1:0]    first;
    int                 src;
    int                 sum;

    always_comb begin
        rot   = '0;
        first = '0;
        src   = 0;
        sum   = 0;

        for (int i = 0; i < int'(Clients); i++) begin
            src = i + int'(start_i);
            if (src >= int'(Clients)) begin
                src = src - int'(Clients);
            end
            rot[IdxW'(i)] = req_i[IdxW'(src)];
        end

        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(Clients) - 1; i >= 0; i--) begin
            if (rot[IdxW'(i)]) begin
                first = IdxW'(i);
            end
        end

        sum = int'(first) + int'(start_i);
        if (sum >= int'(Clients)) begin
            sum = sum - int'(Clients);
        end

        valid_o  = |req_i;
        winner_o = IdxW'(sum);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Non-preemptive round-robin arbiter for one shared memory bus.
//   clk    : system clock, rising edge
//   nRst   : synchronous active-low reset
//   arb_if : slave side of the request/grant bundle (request in, registered grant out)
// The owner keeps the bus for as long as it holds request. Releasing the bus always costs
// one idle cycle, so a falling grant never coincides with a rising one.
module bus_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned Clients = ARB_CLIENTS
) (
    input  logic          clk,
    input  logic          nRst,
    bus_arbiter_if.slave  arb_if
);

    localparam int unsigned IdxW = (Clients > 1) ? $clog2(Clients) : 1;

    arb_state_t         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    rr_q, rr_d;
    logic [Clients-1:0] grant_q, grant_d;

    logic               pick_valid;
    logic [IdxW-1:0]    pick_winner;

    rr_priority_pick #(
        .Clients (Clients),
        .IdxW    (IdxW)
    ) u_pick (
        .req_i    (arb_if.request),
        .start_i  (rr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d              = '0;
                    grant_d[pick_winner] = 1'b1;
                    owner_d              = pick_winner;
                    state_d              = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Other requests are ignored here; they wait until the owner lets go.
                if (!arb_if.request[owner_q]) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                    rr_d    = (owner_q == IdxW'(Clients - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign arb_if.grant = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    import arbiter_pkg::*;

    localparam int N = ARB_CLIENTS;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [N-1:0] req = '0;

    bus_arbiter_if #(.Clients(N)) bus_if ();

    assign bus_if.request = req;

    bus_arbiter #(.Clients(N)) dut (
        .clk    (clk),
        .nRst   (nRst),
        .arb_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus and whose turn it is, from the arbitration rules.
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_req = '0;
    int           own = -1;
    int           ptr = 0;

    always @(posedge clk) begin
        int c;
        logic [N-1:0] e;
        if (!nRst) begin
            own = -1;
            ptr = 0;
        end else if (own < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (own < 0 && req[c]) own = c;
            end
        end else if (!req[own]) begin
            ptr = (own + 1) % N;
            own = -1;
        end
        e = '0;
        if (own >= 0) e[own] = 1'b1;
        exp_q.push_back(e);
        last_req = req;
    end

    // Monitor: compares each registered grant against the model's expectation.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", 32'(bus_if.grant), 32'(e));
            chk("onehot0", 32'($onehot0(bus_if.grant)), 32'd1);
            chk("grant_implies_past_req", 32'(bus_if.grant & ~last_req), 32'd0);
        end
    end

    task automatic wait_grant(input int i, input int budget);
        int n = 0;
        while (bus_if.grant[i] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_grant%0d", i), 32'(bus_if.grant[i]), 32'd1);
    endtask

    logic [15:0] mem [256];
    logic [15:0] rdata;
    int          hold [N];
    int          prev;
    logic [N-1:0] g;

    initial begin
        mem[8'h02] = 16'h0000;

        // Reset then idle with no requests; a sub-cycle pulse must be ignored.
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (5) @(negedge clk);
        #1 req[3] = 1'b1;
        #2 req[3] = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_grant", 32'(bus_if.grant), 32'd0);

        // Writer and reader request together: writer first, reader after idle cycle.
        req = 4'b0011;
        wait_grant(0, 5);
        chk("reader_waits", 32'(bus_if.grant[1]), 32'd0);
        repeat (3) begin
            if (bus_if.grant[0]) mem[8'h02] = 16'hABCD;
            @(negedge clk);
        end
        req[0] = 1'b0;
        @(negedge clk);
        chk("release_idle", 32'(bus_if.grant), 32'd0);
        wait_grant(1, 5);
        rdata = mem[8'h02];
        chk("reader_data", 32'(rdata), 32'h0000ABCD);
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Request from slot 2 arrives while slot 0 owns the bus.
        req[0] = 1'b1;
        wait_grant(0, 5);
        req[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_preempt", 32'(bus_if.grant), 32'b0001);
        req[0] = 1'b0;
        wait_grant(2, 5);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);

        // All four held continuously; each owner releases after 3 cycles then re-requests.
        for (int i = 0; i < N; i++) hold[i] = 0;
        prev = -1;
        req = '1;
        repeat (60) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus_if.grant[i]) begin
                    hold[i]++;
                    if (hold[i] == 1) begin
                        if (prev >= 0) chk("rotation", 32'(i), 32'((prev + 1) % N));
                        prev = i;
                    end
                    if (hold[i] >= 3) begin
                        req[i]  = 1'b0;
                        hold[i] = 0;
                    end
                end else if (!req[i]) begin
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Reset while slot 1 owns the bus; pointer must return to 0.
        req = 4'b0010;
        wait_grant(1, 8);
        nRst = 1'b0;
        req  = '0;
        @(negedge clk);
        chk("reset_drops_grant", 32'(bus_if.grant), 32'd0);
        nRst = 1'b1;
        @(negedge clk);
        req = 4'b1010;
        wait_grant(1, 5);
        chk("post_reset_pick", 32'(bus_if.grant), 32'b0010);
        req = '0;
        repeat (3) @(negedge clk);

        // Randomised traffic, including drops before grant and occasional resets.
        repeat (400) begin
            @(negedge clk);
            g = bus_if.grant;
            nRst = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end
        nRst = 1'b1;
        req  = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
